// File: rtl/dma_reg_readback.sv
// Read side of the DMA register slice: register readback, sticky interrupt status, frame counter and irq.
// Optional macro READ_CLEAR_STATUS_EN: a read of INTERRUPT_STATUS clears the bits it returns.
module dma_reg_readback #(
  parameter int ADDR_DECODER_WIDTH     = 8,
  parameter int LINE_GAP_WIDTH         = 32,
  parameter int CTRL_REG_WIDTH         = 8,
  parameter int GLBL_INT_EN_WIDTH      = 1,
  parameter int INTERRUPT_EN_WIDTH     = 4,
  parameter int INTERRUPT_STATUS_WIDTH = 4,
  parameter int FIFO_LVL_WIDTH         = 8
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              mem_rd_req,
  input  logic [31:0]                       mem_rd_addr,
  output logic                              mem_rd_valid,
  output logic [31:0]                       mem_rd_data,
  input  logic [LINE_GAP_WIDTH-1:0]         line_gap,
  input  logic [CTRL_REG_WIDTH-1:0]         ctrl_reg,
  input  logic [GLBL_INT_EN_WIDTH-1:0]      glbl_int_en,
  input  logic [INTERRUPT_EN_WIDTH-1:0]     interrupt_en,
  input  logic [INTERRUPT_STATUS_WIDTH-1:0] interrupt_status_clr,
  input  logic [INTERRUPT_STATUS_WIDTH-1:0] interrupt_event,
  input  logic                              frame_done,
  input  logic [FIFO_LVL_WIDTH-1:0]         buff_fifo_level,
  input  logic                              buff_fifo_full,
  output logic [INTERRUPT_STATUS_WIDTH-1:0] interrupt_status,
  output logic                              irq
);

  localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_CTRL_REG    = ADDR_DECODER_WIDTH'('h00);
  localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_GLBL_INT_EN = ADDR_DECODER_WIDTH'('h04);
  localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_INT_STATUS  = ADDR_DECODER_WIDTH'('h08);
  localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_INT_EN      = ADDR_DECODER_WIDTH'('h0C);
  localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_LINE_GAP    = ADDR_DECODER_WIDTH'('h10);
  localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_FRAME_CNT   = ADDR_DECODER_WIDTH'('h14);
  localparam logic [ADDR_DECODER_WIDTH-1:0] OFF_BUFF_FIFO   = ADDR_DECODER_WIDTH'('h18);

  logic                              vld_p0;
  logic [ADDR_DECODER_WIDTH-1:0]     addr_p0;
  logic [31:0]                       rd_mux_p0;
  logic [31:0]                       frame_cnt;
  logic                              start_d;
  logic [INTERRUPT_STATUS_WIDTH-1:0] rdclr;
  logic [INTERRUPT_STATUS_WIDTH-1:0] int_en_ext;
  logic                              unused_addr_bits;

  assign unused_addr_bits = ^mem_rd_addr[31:ADDR_DECODER_WIDTH];
  assign int_en_ext       = INTERRUPT_STATUS_WIDTH'(interrupt_en);

  // Stage p0: capture request and decoded address bits
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) vld_p0 <= 1'b0;
    else          vld_p0 <= mem_rd_req;
  end

  always_ff @(posedge aclk) begin
    addr_p0 <= mem_rd_addr[ADDR_DECODER_WIDTH-1:0];
  end

  always_comb begin
    rd_mux_p0 = 32'h0;
    case (addr_p0)
      OFF_CTRL_REG:    rd_mux_p0 = 32'(ctrl_reg);
      OFF_GLBL_INT_EN: rd_mux_p0 = 32'(glbl_int_en);
      OFF_INT_STATUS:  rd_mux_p0 = 32'(interrupt_status);
      OFF_INT_EN:      rd_mux_p0 = 32'(interrupt_en);
      OFF_LINE_GAP:    rd_mux_p0 = 32'(line_gap);
      OFF_FRAME_CNT:   rd_mux_p0 = frame_cnt;
      OFF_BUFF_FIFO:   rd_mux_p0 = {buff_fifo_full, {(31-FIFO_LVL_WIDTH){1'b0}}, buff_fifo_level};
      default:         rd_mux_p0 = 32'h0;
    endcase
  end

`ifdef READ_CLEAR_STATUS_EN
  assign rdclr = (vld_p0 && (addr_p0 == OFF_INT_STATUS)) ? interrupt_status : '0;
`else
  assign rdclr = '0;
`endif

  // Stage p1: registered response; data holds between responses
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem_rd_valid <= 1'b0;
      mem_rd_data  <= 32'h0;
    end else begin
      mem_rd_valid <= vld_p0;
      if (vld_p0) mem_rd_data <= rd_mux_p0;
    end
  end

  // Events are ORed in last so they win over any same-cycle clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      interrupt_status <= '0;
      irq              <= 1'b0;
    end else begin
      interrupt_status <= (interrupt_status & ~interrupt_status_clr & ~rdclr) | interrupt_event;
      irq              <= glbl_int_en[0] & (|(interrupt_status & int_en_ext));
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt <= 32'h0;
      start_d   <= 1'b0;
    end else begin
      start_d <= ctrl_reg[0];
      if (ctrl_reg[0] && !start_d) frame_cnt <= 32'h0;
      else if (frame_done)         frame_cnt <= frame_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_dma_reg_readback.sv
// Directed self-checking bench for dma_reg_readback; expectations follow the READ_CLEAR_STATUS_EN setting.
module tb_dma_reg_readback;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        mem_rd_req = 1'b0;
  logic [31:0] mem_rd_addr = 32'h0;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic [31:0] line_gap = 32'h0;
  logic [7:0]  ctrl_reg = 8'h0;
  logic [0:0]  glbl_int_en = 1'b0;
  logic [3:0]  interrupt_en = 4'h0;
  logic [3:0]  interrupt_status_clr = 4'h0;
  logic [3:0]  interrupt_event = 4'h0;
  logic        frame_done = 1'b0;
  logic [7:0]  buff_fifo_level = 8'h0;
  logic        buff_fifo_full = 1'b0;
  logic [3:0]  interrupt_status;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  dma_reg_readback dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .mem_rd_req           (mem_rd_req),
    .mem_rd_addr          (mem_rd_addr),
    .mem_rd_valid         (mem_rd_valid),
    .mem_rd_data          (mem_rd_data),
    .line_gap             (line_gap),
    .ctrl_reg             (ctrl_reg),
    .glbl_int_en          (glbl_int_en),
    .interrupt_en         (interrupt_en),
    .interrupt_status_clr (interrupt_status_clr),
    .interrupt_event      (interrupt_event),
    .frame_done           (frame_done),
    .buff_fifo_level      (buff_fifo_level),
    .buff_fifo_full       (buff_fifo_full),
    .interrupt_status     (interrupt_status),
    .irq                  (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Single read; returns at the negedge after the response edge
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge aclk);
    mem_rd_req  = 1'b1;
    mem_rd_addr = addr;
    @(negedge aclk);
    mem_rd_req = 1'b0;
    check_eq({tag, "_early"}, 32'(mem_rd_valid), 32'h0);
    @(negedge aclk);
    check_eq({tag, "_vld"}, 32'(mem_rd_valid), 32'h1);
    check_eq(tag, mem_rd_data, exp);
  endtask

  task automatic pulse_frame();
    @(negedge aclk);
    frame_done = 1'b1;
    @(negedge aclk);
    frame_done = 1'b0;
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_exp  [4];
  int          vld_cnt;

  initial begin
    // Reset state
    repeat (2) @(negedge aclk);
    check_eq("rst_valid",  32'(mem_rd_valid), 32'h0);
    check_eq("rst_data",   mem_rd_data, 32'h0);
    check_eq("rst_status", 32'(interrupt_status), 32'h0);
    check_eq("rst_irq",    32'(irq), 32'h0);
    aresetn = 1'b1;

    // Single read, LINE_GAP
    line_gap = 32'h0000_2000;
    do_read("rd_line_gap", 32'h10, 32'h0000_2000);

    // Back-to-back reads, including an unmapped one
    ctrl_reg = 8'hA4; glbl_int_en = 1'b1; interrupt_en = 4'h9;
    b2b_addr[0] = 32'h00; b2b_exp[0] = 32'h0000_00A4;
    b2b_addr[1] = 32'h04; b2b_exp[1] = 32'h0000_0001;
    b2b_addr[2] = 32'h0C; b2b_exp[2] = 32'h0000_0009;
    b2b_addr[3] = 32'h40; b2b_exp[3] = 32'h0;
    for (int c = 0; c < 7; c++) begin
      @(negedge aclk);
      if (c >= 2 && c < 6) begin
        check_eq($sformatf("b2b_vld%0d", c-2), 32'(mem_rd_valid), 32'h1);
        check_eq($sformatf("b2b_data%0d", c-2), mem_rd_data, b2b_exp[c-2]);
      end
      if (c == 6) check_eq("b2b_vld_end", 32'(mem_rd_valid), 32'h0);
      mem_rd_req  = (c < 4);
      mem_rd_addr = (c < 4) ? b2b_addr[c] : 32'h0;
    end
    mem_rd_req = 1'b0;

    // FIFO status and full address decode
    buff_fifo_level = 8'h5A; buff_fifo_full = 1'b1;
    do_read("rd_fifo_stat", 32'hFFFF_FF18, 32'h8000_005A);

    // Sticky status and irq
    glbl_int_en = 1'b0; interrupt_en = 4'h0;
    @(negedge aclk); interrupt_event = 4'b0101;
    @(negedge aclk); interrupt_event = 4'b0000;
    check_eq("status_set", 32'(interrupt_status), 32'h5);
    check_eq("irq_masked", 32'(irq), 32'h0);
    interrupt_en = 4'b0100; glbl_int_en = 1'b1;
    @(negedge aclk);
    check_eq("irq_set", 32'(irq), 32'h1);
    interrupt_status_clr = 4'b0100; interrupt_event = 4'b0100;
    @(negedge aclk);
    interrupt_status_clr = 4'b0000; interrupt_event = 4'b0000;
    check_eq("status_evt_wins", 32'(interrupt_status), 32'h5);
    interrupt_status_clr = 4'b0001;
    @(negedge aclk);
    interrupt_status_clr = 4'b0000;
    check_eq("status_clr", 32'(interrupt_status), 32'h4);
    glbl_int_en = 1'b0;
    @(negedge aclk);
    check_eq("irq_glbl_off", 32'(irq), 32'h0);

    // Frame counter
    repeat (3) pulse_frame();
    do_read("rd_frame3", 32'h14, 32'h3);
    @(negedge aclk); ctrl_reg = 8'hA5; frame_done = 1'b1;
    @(negedge aclk); frame_done = 1'b0;
    do_read("rd_frame_start_clr", 32'h14, 32'h0);
    @(negedge aclk);
    force dut.frame_cnt = 32'hFFFF_FFFF;
    #1 release dut.frame_cnt;
    frame_done = 1'b1;
    @(negedge aclk); frame_done = 1'b0;
    do_read("rd_frame_wrap", 32'h14, 32'h0);
    pulse_frame();
    do_read("rd_frame_after_wrap", 32'h14, 32'h1);

    // Read-clear behaviour of INTERRUPT_STATUS
    @(negedge aclk); interrupt_status_clr = 4'hF; interrupt_event = 4'b0011;
    @(negedge aclk); interrupt_status_clr = 4'h0; interrupt_event = 4'h0;
    check_eq("status_3", 32'(interrupt_status), 32'h3);
    interrupt_en = 4'b0011; glbl_int_en = 1'b1;
    @(negedge aclk);
    check_eq("irq_pre_rd", 32'(irq), 32'h1);
    do_read("rd_status", 32'h08, 32'h3);
`ifdef READ_CLEAR_STATUS_EN
    check_eq("status_after_rd", 32'(interrupt_status), 32'h0);
    check_eq("irq_lag", 32'(irq), 32'h1);
    @(negedge aclk);
    check_eq("irq_after_rd", 32'(irq), 32'h0);
`else
    check_eq("status_after_rd", 32'(interrupt_status), 32'h3);
    @(negedge aclk);
    check_eq("irq_after_rd", 32'(irq), 32'h1);
`endif

    // Reset with reads in flight
    @(negedge aclk); mem_rd_req = 1'b1; mem_rd_addr = 32'h10; interrupt_event = 4'b0010;
    @(negedge aclk); mem_rd_addr = 32'h04; interrupt_event = 4'b0000;
    #1 aresetn = 1'b0;
    mem_rd_req = 1'b0;
    #1;
    check_eq("mid_rst_valid",  32'(mem_rd_valid), 32'h0);
    check_eq("mid_rst_data",   mem_rd_data, 32'h0);
    check_eq("mid_rst_status", 32'(interrupt_status), 32'h0);
    check_eq("mid_rst_irq",    32'(irq), 32'h0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    vld_cnt = 0;
    repeat (6) begin
      @(negedge aclk);
      if (mem_rd_valid) vld_cnt++;
    end
    check_eq("post_rst_no_valid", 32'(vld_cnt), 32'h0);
    check_eq("post_rst_irq", 32'(irq), 32'h0);
    do_read("rd_frame_post_rst", 32'h14, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
